// File: rtl/counter_pkg.sv
// Shared constants and next-count arithmetic for the up/down event counter.
// The function is width-generic: callers zero-extend into CNT_MAX_W bits.
package counter_pkg;

  localparam bit CNT_WRAP = 1'b0;
  localparam bit CNT_SAT  = 1'b1;

  localparam int CNT_MAX_W = 32;

  // Returns {tc, next_result}. result is assumed to already be <= max_val.
  function automatic logic [CNT_MAX_W:0] next_count(
    input logic [CNT_MAX_W-1:0] result,
    input logic [CNT_MAX_W-1:0] step,
    input logic                 up_dn,
    input logic [CNT_MAX_W-1:0] max_val,
    input logic                 sat
  );
    logic [CNT_MAX_W:0]   sum;
    logic [CNT_MAX_W:0]   modulus;
    logic [CNT_MAX_W-1:0] nxt;
    logic                 tc;
    modulus = {1'b0, max_val} + (CNT_MAX_W+1)'(1);
    sum     = '0;
    nxt     = result;
    tc      = 1'b0;
    if (up_dn) begin
      sum = {1'b0, result} + {1'b0, step};
      if (sum > {1'b0, max_val}) begin
        tc  = 1'b1;
        nxt = sat ? max_val : CNT_MAX_W'(sum - modulus);
      end else begin
        nxt = sum[CNT_MAX_W-1:0];
      end
    end else begin
      if (step > result) begin
        tc  = 1'b1;
        nxt = sat ? '0 : CNT_MAX_W'({1'b0, result} + modulus - {1'b0, step});
      end else begin
        nxt = result - step;
      end
    end
    return {tc, nxt};
  endfunction

endpackage

// File: rtl/param_updown_counter_if.sv
// Control and status bundle of the up/down counter.
// master drives the controls, slave is the counter itself.
interface param_updown_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              ena;
  logic              clr;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              up_dn;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  result;
  logic              tc;
  logic              ovf;
  logic              zero;

  modport master (
    output ena, clr, load, load_val, up_dn, step,
    input  result, tc, ovf, zero
  );

  modport slave (
    input  ena, clr, load, load_val, up_dn, step,
    output result, tc, ovf, zero
  );
endinterface

// File: rtl/cnt_step_alu.sv
// Combinational next value and terminal-count for one enabled step.
// Zero latency, no flow control; wraps or clamps according to SATURATE.
module cnt_step_alu
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = 0,
  parameter int STEP_W   = 4
) (
  input  logic [WIDTH-1:0]  cur,
  input  logic [STEP_W-1:0] step,
  input  logic              up_dn,
  output logic [WIDTH-1:0]  nxt,
  output logic              tc
);

  localparam bit SAT_MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  logic [CNT_MAX_W:0] res;

  always_comb begin
    res = next_count(CNT_MAX_W'(cur), CNT_MAX_W'(step), up_dn,
                     CNT_MAX_W'(MAX_VAL), SAT_MODE);
  end

  assign nxt = res[WIDTH-1:0];
  assign tc  = res[CNT_MAX_W];

  // Bits above WIDTH are always zero because results never exceed MAX_VAL.
  logic unused_hi;
  assign unused_hi = ^res[CNT_MAX_W-1:WIDTH];

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, clear, wrap/saturate, tc pulse and sticky ovf.
// result/tc update one edge after inputs are sampled; no backpressure, accepts every cycle.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int SATURATE = 0,
  parameter int STEP_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  param_updown_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH >= CNT_MAX_W) begin : g_bad_width
    $error("param_updown_counter: WIDTH out of range");
  end
  if (MAX_VAL < 1 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $error("param_updown_counter: MAX_VAL out of range");
  end
  if (((1 << STEP_W) - 1) > MAX_VAL) begin : g_bad_step
    $error("param_updown_counter: largest step exceeds MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] result_q;
  logic             tc_q;
  logic             ovf_q;
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_tc;
  logic [WIDTH-1:0] load_clamped;

  cnt_step_alu #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE),
    .STEP_W   (STEP_W)
  ) u_alu (
    .cur   (result_q),
    .step  (bus.step),
    .up_dn (bus.up_dn),
    .nxt   (alu_nxt),
    .tc    (alu_tc)
  );

  assign load_clamped = (bus.load_val > MAX_W) ? MAX_W : bus.load_val;

  // Priority: reset > clr > load > ena; tc defaults low so it only pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result_q <= '0;
      tc_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.clr) begin
      result_q <= '0;
      tc_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.load) begin
      result_q <= load_clamped;
      tc_q     <= 1'b0;
    end else if (bus.ena) begin
      result_q <= alu_nxt;
      tc_q     <= alu_tc;
      ovf_q    <= ovf_q | alu_tc;
    end else begin
      tc_q     <= 1'b0;
    end
  end

  assign bus.result = result_q;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = (result_q == '0);

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised successor to the team's 8-bit enable counter. Adds configurable width and modulus, up/down direction, variable step, synchronous load and clear, and a wrap or saturate mode. Emits a registered terminal-count pulse and a sticky overflow flag. Used as the general-purpose event/timer counter in control paths.

Parameters:
WIDTH, 8, counter width in bits
MAX_VAL, 2**WIDTH-1, highest count value; the counter is modulo MAX_VAL+1; legal range 1..2**WIDTH-1
SATURATE, 0, 0 = wrap modulo MAX_VAL+1; 1 = clamp at MAX_VAL (up) or 0 (down)
STEP_W, 4, width of the step input; elaboration error if 2**STEP_W-1 > MAX_VAL

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-low reset
ena  input  1  count enable
clr  input  1  synchronous clear of count and overflow flag
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value to load
up_dn  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment/decrement amount per enabled cycle
result  output  WIDTH  current count (registered)
tc  output  1  registered one-cycle pulse on wrap or saturate event
ovf  output  1  sticky flag, set on any tc event
zero  output  1  combinational, result == 0

Behaviour:
- Reset (reset==0 at a clk edge): result=0, tc=0, ovf=0. Reset overrides all other inputs, including mid-operation.
- Priority at each edge: reset > clr > load > ena. Lower-priority inputs are ignored when a higher one is active.
- clr: result=0, ovf=0, tc=0.
- load: result = min(load_val, MAX_VAL). tc=0. ovf is unchanged.
- ena=0 with no clr/load: result holds and tc=0.
- ena=1, step==0: result holds, tc=0.
- Arithmetic is computed at WIDTH+1 bits internally to avoid silent truncation.
- Up (up_dn=1), sum = result + step:
  - sum <= MAX_VAL: result=sum, tc=0.
  - sum > MAX_VAL with SATURATE=0: result = sum - (MAX_VAL+1), tc=1, ovf=1.
  - sum > MAX_VAL with SATURATE=1: result = MAX_VAL, tc=1, ovf=1.
  - At saturation, every further enabled up-step pulses tc again.
- Down (up_dn=0):
  - step <= result: result = result - step, tc=0.
  - step > result with SATURATE=0: result = result + (MAX_VAL+1) - step, tc=1, ovf=1.
  - step > result with SATURATE=1: result = 0, tc=1, ovf=1.
- Latency: result and tc update on the same edge, one cycle after the inputs are sampled. zero follows result combinationally.
- tc is high for exactly one cycle per triggering edge. It stays high on consecutive cycles only if consecutive edges each trigger.
- ovf stays set until clr or reset. If clr and an overflow condition occur on the same edge, clr wins and ovf=0.
- Direction change takes effect on the next enabled edge. There is no extra latency.
- No X propagation: all outputs are defined from the first edge after reset is asserted.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants CNT_WRAP=0 and CNT_SAT=1;
  - a function next_count(result, step, up_dn, max_val, sat) returning {tc, next_result}. Both the RTL and the bench scoreboard use it.
- One natural sub-module, cnt_step_alu: combinational next-value and tc computation. The top level holds the registers, priority logic and ovf.

Test Plan:
- Reset/hold: WIDTH=8, reset=0 for 2 cycles with ena=1 -> result=0, tc=0, ovf=0. Release reset with ena=0 for 5 cycles -> result stays 0.
- Wrap up, MAX_VAL=9, step=3, from 0, ena=1 -> result sequence 3,6,9,2. tc=1 only on the edge producing 2. ovf=1 after that edge and stays 1.
- Wrap down, MAX_VAL=9, load 1, then step=4, up_dn=0 -> result 7, tc=1 on that edge. Next edge -> 3, tc=0.
- Saturate, SATURATE=1, MAX_VAL=255, load 250, step=4 up:
  - result 254, then 255 with tc=1, then 255 with tc=1;
  - switch up_dn=0 -> 251 with tc=0.
- Priority: clr=1, load=1 with load_val=5, ena=1 on one edge -> result=0, ovf=0. Next edge with load=1 only, load_val=200 and MAX_VAL=99 -> result=99.
- Mid-operation reset: counting up at result=7 with ovf=1, drive reset=0 for 1 edge -> result=0, ovf=0, tc=0. Counting resumes from 0 on the next enabled edge.
